// File: rtl/prbs_chk_pkg.sv
// Shared types and helpers for the 16-lane PRBS receive checker.
// Optional per-lane error counters in prbs_checker_16 are enabled by PRBS_CHK_LANE_CNT_EN.
package prbs_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        HUNT   = 2'd2,
        LOCKED = 2'd3
    } chk_state_t;

    localparam logic [31:0] PRBS_EQN_DEFAULT = 32'h0010_0002;

    localparam int POP_LANES = 16;
    localparam int POP_W     = $clog2(POP_LANES + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [POP_LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_lane_chk.sv
// One self-synchronising PRBS lane checker: history of received bits, tap prediction
// and registered mismatch flag.
module prbs_lane_chk
    import prbs_chk_pkg::*;
#(
    parameter int                N_PRBS = 32,
    parameter logic [N_PRBS-1:0] EQN    = N_PRBS'(PRBS_EQN_DEFAULT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift,
    input  logic chk,
    input  logic b,
    output logic mis,
    output logic lane_err
);

    logic [N_PRBS-1:0] hist;

    // History holds received bits only, so a single channel error shows up once
    // directly and once more for every tap it passes through.
    assign mis = (^(hist & EQN)) != b;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist     <= '0;
            lane_err <= 1'b0;
        end else if (shift) begin
            hist     <= {hist[N_PRBS-2:0], b};
            lane_err <= chk & mis;
        end else begin
            lane_err <= 1'b0;
        end
    end

endmodule

// File: rtl/prbs_checker_16.sv
// 16-lane PRBS receive checker with lock FSM and saturating bit-error counter.
// Defining PRBS_CHK_LANE_CNT_EN adds lane_err_cnt, one saturating 16-bit counter per lane.
module prbs_checker_16
    import prbs_chk_pkg::*;
#(
    parameter int                N_LANES    = 16,
    parameter int                N_PRBS     = 32,
    parameter logic [N_PRBS-1:0] EQN        = N_PRBS'(PRBS_EQN_DEFAULT),
    parameter int                LOCK_CNT   = 64,
    parameter int                UNLOCK_THR = 8,
    parameter int                CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_LANES-1:0] din,
    input  logic               din_valid,
    input  logic               inv,
    input  logic               clr_cnt,
    output logic [N_LANES-1:0] lane_err,
    output logic               locked,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   err_cnt
`ifdef PRBS_CHK_LANE_CNT_EN
    ,
    output logic [N_LANES*16-1:0] lane_err_cnt
`endif
);

    localparam int FILL_W  = $clog2(N_PRBS + 1);
    localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W   = $clog2(UNLOCK_THR + 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - POP_W){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    chk_state_t         st, st_nxt;
    logic [FILL_W-1:0]  fill_cnt, fill_nxt;
    logic [CLEAN_W-1:0] clean_cnt, clean_nxt;
    logic [BAD_W-1:0]   bad_cnt, bad_nxt;
    logic [N_LANES-1:0] mis;
    logic               any_err;
    logic               shift;
    logic               vld_p1;

    assign shift   = en && din_valid && (st != IDLE);
    assign any_err = |mis;
    assign state   = st;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        prbs_lane_chk #(
            .N_PRBS (N_PRBS),
            .EQN    (EQN)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (!en),
            .shift    (shift),
            .chk      (st != FILL),
            .b        (din[i] ^ inv),
            .mis      (mis[i]),
            .lane_err (lane_err[i])
        );
    end

    always_comb begin
        st_nxt    = st;
        fill_nxt  = fill_cnt;
        clean_nxt = clean_cnt;
        bad_nxt   = bad_cnt;
        if (!en) begin
            st_nxt    = IDLE;
            fill_nxt  = '0;
            clean_nxt = '0;
            bad_nxt   = '0;
        end else begin
            case (st)
                IDLE: begin
                    st_nxt    = FILL;
                    fill_nxt  = '0;
                    clean_nxt = '0;
                    bad_nxt   = '0;
                end
                FILL: if (din_valid) begin
                    if (fill_cnt == FILL_W'(N_PRBS - 1)) begin
                        st_nxt    = HUNT;
                        clean_nxt = '0;
                    end else begin
                        fill_nxt = fill_cnt + FILL_W'(1);
                    end
                end
                HUNT: if (din_valid) begin
                    if (any_err) begin
                        clean_nxt = '0;
                    end else if (clean_cnt == CLEAN_W'(LOCK_CNT - 1)) begin
                        st_nxt  = LOCKED;
                        bad_nxt = '0;
                    end else begin
                        clean_nxt = clean_cnt + CLEAN_W'(1);
                    end
                end
                LOCKED: if (din_valid) begin
                    if (!any_err) begin
                        bad_nxt = '0;
                    end else if (bad_cnt == BAD_W'(UNLOCK_THR - 1)) begin
                        st_nxt    = HUNT;
                        clean_nxt = '0;
                    end else begin
                        bad_nxt = bad_cnt + BAD_W'(1);
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            fill_cnt  <= '0;
            clean_cnt <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            st        <= st_nxt;
            fill_cnt  <= fill_nxt;
            clean_cnt <= clean_nxt;
            bad_cnt   <= bad_nxt;
            locked    <= (st_nxt == LOCKED);
            vld_p1    <= en && din_valid && (st == LOCKED);
        end
    end

    // p1 -> p2: lane_err produced while LOCKED is accumulated one cycle later
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            err_cnt <= '0;
        end else if (vld_p1) begin
            err_cnt <= sat_add(err_cnt, popcount(lane_err));
        end
    end

`ifdef PRBS_CHK_LANE_CNT_EN
    for (genvar i = 0; i < N_LANES; i++) begin : g_lcnt
        always_ff @(posedge clk) begin
            if (rst || clr_cnt) begin
                lane_err_cnt[i*16 +: 16] <= '0;
            end else if (vld_p1 && lane_err[i] && (lane_err_cnt[i*16 +: 16] != 16'hFFFF)) begin
                lane_err_cnt[i*16 +: 16] <= lane_err_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_checker_16.sv
// Randomised self-checking bench for prbs_checker_16 against a word-level reference model.
module tb_prbs_checker_16;

    localparam int          NL   = 16;
    localparam int          NP   = 32;
    localparam int          LOCK = 64;
    localparam int          UNL  = 8;
    localparam int          CW   = 8;
    localparam logic [31:0] EQN  = 32'h0010_0002;
    localparam longint      CMAX = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, en, din_valid, inv, clr_cnt;
    logic [NL-1:0] din, lane_err;
    logic          locked;
    logic [1:0]    state;
    logic [CW-1:0] err_cnt;
`ifdef PRBS_CHK_LANE_CNT_EN
    logic [NL*16-1:0] lane_err_cnt;
`endif

    always #5 clk = ~clk;

    prbs_checker_16 #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .inv       (inv),
        .clr_cnt   (clr_cnt),
        .lane_err  (lane_err),
        .locked    (locked),
        .state     (state),
        .err_cnt   (err_cnt)
`ifdef PRBS_CHK_LANE_CNT_EN
        ,
        .lane_err_cnt (lane_err_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: rxh[i][k] is the bit received k+1 valid words ago.
    int          m_state, m_fill, m_clean, m_bad;
    bit [NL-1:0] m_lerr;
    longint      m_err;
    bit          m_vld;
    bit          rxh[NL][NP];
    logic [31:0] g[NL];
    logic [NL-1:0] w, d;
    int unsigned r;

    function automatic bit m_pred(int i);
        bit p = 1'b0;
        for (int k = 0; k < NP; k++) if (EQN[k]) p ^= rxh[i][k];
        return p;
    endfunction

    function automatic bit would_err(logic [NL-1:0] x);
        for (int i = 0; i < NL; i++) if ((x[i] ^ inv) != m_pred(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int popc(bit [NL-1:0] v);
        int n = 0;
        for (int i = 0; i < NL; i++) n += v[i];
        return n;
    endfunction

    task automatic tx_word(output logic [NL-1:0] o);
        for (int i = 0; i < NL; i++) begin
            o[i] = ^(g[i] & EQN);
            g[i] = {g[i][30:0], o[i]};
        end
    endtask

    function automatic void model_step();
        bit [NL-1:0] mis;
        longint ne;
        if (rst) begin
            m_state = 0; m_fill = 0; m_clean = 0; m_bad = 0;
            m_lerr = '0; m_err = 0; m_vld = 1'b0;
            for (int i = 0; i < NL; i++) for (int k = 0; k < NP; k++) rxh[i][k] = 1'b0;
            return;
        end
        for (int i = 0; i < NL; i++) mis[i] = (din[i] ^ inv) != m_pred(i);
        ne = m_err;
        if (clr_cnt) ne = 0;
        else if (m_vld) begin
            ne = m_err + popc(m_lerr);
            if (ne > CMAX) ne = CMAX;
        end
        m_err  = ne;
        m_vld  = en && din_valid && (m_state == 3);
        m_lerr = (en && din_valid && m_state >= 2) ? mis : '0;
        for (int i = 0; i < NL; i++) begin
            if (!en) for (int k = 0; k < NP; k++) rxh[i][k] = 1'b0;
            else if (din_valid && m_state != 0) begin
                for (int k = NP - 1; k > 0; k--) rxh[i][k] = rxh[i][k-1];
                rxh[i][0] = din[i] ^ inv;
            end
        end
        if (!en) begin
            m_state = 0; m_fill = 0; m_clean = 0; m_bad = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_fill = 0; m_clean = 0; m_bad = 0;
        end else if (din_valid) begin
            if (m_state == 1) begin
                m_fill++;
                if (m_fill == NP) begin m_state = 2; m_clean = 0; end
            end else if (m_state == 2) begin
                if (mis != 0) m_clean = 0;
                else begin
                    m_clean++;
                    if (m_clean == LOCK) begin m_state = 3; m_bad = 0; end
                end
            end else begin
                if (mis == 0) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == UNL) begin m_state = 2; m_clean = 0; end
                end
            end
        end
    endfunction

    task automatic tick(input logic [NL-1:0] x, input logic v);
        din = x;
        din_valid = v;
        @(posedge clk);
        #1;
        model_step();
        check("state", longint'(state), longint'(m_state));
        check("locked", longint'(locked), longint'(m_state == 3));
        check("lane_err", longint'(lane_err), longint'(m_lerr));
        check("err_cnt", longint'(err_cnt), m_err);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; inv = 1'b0; clr_cnt = 1'b0; din = '0;
        for (int i = 0; i < NL; i++) g[i] = $urandom | 32'h1;
        repeat (3) tick('0, 1'b0);
        check("rst_state", longint'(state), 0);
        check("rst_err_cnt", longint'(err_cnt), 0);

        // Clean lock
        rst = 1'b0; en = 1'b1;
        tick('0, 1'b0);
        check("fill_entry", longint'(state), 1);
        for (int n = 0; n < 96; n++) begin
            tx_word(w); tick(w, 1'b1);
            if (n == 31) check("hunt_after_fill", longint'(state), 2);
            if (n == 94) check("hunt_before_lock", longint'(state), 2);
        end
        check("lock_at_96", longint'(locked), 1);
        check("clean_err_cnt", longint'(err_cnt), 0);

        // Single bit error on lane 5
        pulses = 0;
        tx_word(w); w[5] = ~w[5]; tick(w, 1'b1); pulses += lane_err[5];
        for (int n = 0; n < 25; n++) begin
            tx_word(w); tick(w, 1'b1); pulses += lane_err[5];
        end
        check("flip_pulses", pulses, 3);
        check("flip_err_cnt", longint'(err_cnt), 3);

        // Loss of lock: eight errored words
        for (int n = 0; n < UNL; n++) begin
            tx_word(w);
            d = w ^ NL'(32'h1);
            for (int t = 0; t < 100; t++) begin
                r = $urandom; d = w ^ r[NL-1:0];
                if (would_err(d)) break;
            end
            tick(d, 1'b1);
        end
        check("unlock_after_8", longint'(state), 2);
        for (int n = 0; n < 130; n++) begin tx_word(w); tick(w, 1'b1); end
        check("relock", longint'(locked), 1);

        // Saturation under spaced error bursts, then clear against an error
        for (int n = 0; n < 160; n++) begin
            tx_word(w);
            if (n % 4 == 0 && n < 120) begin r = $urandom_range(1, 65535); w = w ^ r[NL-1:0]; end
            tick(w, 1'b1);
        end
        check("sat_err_cnt", longint'(err_cnt), CMAX);
        check("sat_locked", longint'(locked), 1);
        tx_word(w); w[0] = ~w[0]; tick(w, 1'b1);
        clr_cnt = 1'b1; tx_word(w); tick(w, 1'b1); clr_cnt = 1'b0;
        check("clr_priority", longint'(err_cnt), 0);
        for (int n = 0; n < 30; n++) begin tx_word(w); tick(w, 1'b1); end

        // en drop while locked
        en = 1'b0; tx_word(w); tick(w, 1'b1);
        check("en0_state", longint'(state), 0);
        check("en0_locked", longint'(locked), 0);
        check("en0_lane_err", longint'(lane_err), 0);
        en = 1'b1; tick('0, 1'b0);
        for (int n = 0; n < 97; n++) begin tx_word(w); tick(w, 1'b1); end
        check("relock_en", longint'(locked), 1);
        tx_word(w); w[3] = ~w[3]; tick(w, 1'b1);
        repeat (3) begin tx_word(w); tick(w, 1'b1); end

        // Reset while locked
        rst = 1'b1; tx_word(w); tick(w, 1'b1); rst = 1'b0;
        check("rst_run_state", longint'(state), 0);
        check("rst_run_locked", longint'(locked), 0);
        check("rst_run_lane_err", longint'(lane_err), 0);
        check("rst_run_err_cnt", longint'(err_cnt), 0);

        // Valid gaps
        tick('0, 1'b0);
        for (int n = 0; n < 96; n++) begin
            tx_word(w); tick(w, 1'b1);
            r = $urandom; tick(r[NL-1:0], 1'b0);
        end
        check("gap_lock", longint'(locked), 1);

        // Inverted leg
        rst = 1'b1; tick('0, 1'b0); rst = 1'b0; inv = 1'b1; tick('0, 1'b0);
        for (int n = 0; n < 96; n++) begin tx_word(w); tick(~w, 1'b1); end
        check("inv_lock", longint'(locked), 1);
        rst = 1'b1; tick('0, 1'b0); rst = 1'b0; inv = 1'b0; tick('0, 1'b0);
        for (int n = 0; n < 150; n++) begin tx_word(w); tick(~w, 1'b1); end
        check("inv_wrong_hunt", longint'(state), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
